// File: rtl/bus_control_pkg.sv
// Shared types and address-map constants for the bus_control_ws 68000 bus controller.
package bus_control_pkg;

  typedef enum logic [1:0] {
    REG_LOWER,
    REG_IO,
    REG_UPPER,
    REG_UNMAPPED
  } region_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PAUSE,
    S_ACK,
    S_BERR
  } state_t;

  localparam logic [3:0]  LOWER_NIB = 4'h0;
  localparam logic [3:0]  IO_NIB    = 4'h1;
  localparam logic [3:0]  UPPER_NIB = 4'hF;
  localparam logic [23:0] IO_BASE   = 24'h100000;

  function automatic logic [3:0] wait_load(input int unsigned w);
    return (w > 15) ? 4'hF : 4'(w);
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational region / I/O port decode of the 24-bit CPU address.
module bus_addr_decoder
  import bus_control_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 1
) (
  input  logic [23:0] addr_i,
  output region_t     region_o,
  output logic [3:0]  port_idx_o,
  output logic        port_in_o
);

  localparam logic [17:0] NPORTS = 18'(NUM_PORTS);

  logic [19:0] offset;

  always_comb begin
    offset     = addr_i[19:0] - IO_BASE[19:0];
    port_idx_o = offset[5:2];
    port_in_o  = offset[1];
    case (addr_i[23:20])
      LOWER_NIB: region_o = REG_LOWER;
      UPPER_NIB: region_o = REG_UPPER;
      // Port k lives at offset 4k+1 (out) / 4k+3 (in); anything else in the window faults
      IO_NIB:    region_o = (offset[0] && (offset[19:2] < NPORTS)) ? REG_IO : REG_UNMAPPED;
      default:   region_o = REG_UNMAPPED;
    endcase
  end

endmodule

// File: rtl/bus_control_ws.sv
// 68000 bus controller: PROM overlay decode, chip selects, wait-state/stepper DTACK FSM,
// I/O port bank and BERR on unmapped access or timeout.
module bus_control_ws
  import bus_control_pkg::*;
#(
  parameter int unsigned PROM_WAIT = 2,
  parameter int unsigned SRAM_WAIT = 0,
  parameter int unsigned IO_WAIT   = 0,
  parameter int unsigned NUM_PORTS = 1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                   CPUCLK_IN,
  input  logic                   RUN_IN,
  input  logic                   STEPEN_IN,
  input  logic                   STEP_IN,
  input  logic                   AS_IN,
  input  logic                   WR_IN,
  input  logic                   UDS_IN,
  input  logic                   LDS_IN,
  input  logic [23:0]            ADDR_IN,
  input  logic [15:0]            DATA_IN,
  input  logic [8*NUM_PORTS-1:0] INPUT_SIGNAL_IN,
  output logic [15:0]            DATA_OUT,
  output logic                   DATA_OE,
  output logic                   DTACK,
  output logic                   BERR,
  output logic                   PROMCS0,
  output logic                   PROMCS1,
  output logic                   SRAMCS0,
  output logic                   SRAMCS1,
  output logic                   OE,
  output logic [8*NUM_PORTS-1:0] OUTPUT_SIGNAL
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  region_t    region;
  logic [3:0] port_idx;
  logic       port_in;

  bus_addr_decoder #(.NUM_PORTS(NUM_PORTS)) u_dec (
    .addr_i     (ADDR_IN),
    .region_o   (region),
    .port_idx_o (port_idx),
    .port_in_o  (port_in)
  );

  state_t                 state_q, state_d;
  region_t                region_q, region_d;
  logic [3:0]             wait_q, wait_d;
  logic [15:0]            to_q, to_d;
  logic [3:0]             idx_q, idx_d;
  logic                   in_q, in_d;
  logic                   read_q, read_d;
  logic                   boot_q, boot_d;
  logic                   dtack_q, dtack_d;
  logic                   berr_q, berr_d;
  logic                   doe_q, doe_d;
  logic [15:0]            dout_q, dout_d;
  logic [8*NUM_PORTS-1:0] out_q, out_d;
  logic                   step_sync_q, step_prev_q;

  logic       prom_sel, sram_sel, dtreq, step_rise, ack_entry;
  logic [7:0] rd_byte;
  logic       unused_data;

  assign unused_data = ^DATA_IN[15:8];

  assign prom_sel  = (region == REG_UPPER) || ((region == REG_LOWER) && !WR_IN && !boot_q);
  assign sram_sel  = (region == REG_LOWER) && (WR_IN || boot_q);
  assign PROMCS0   = RUN_IN && AS_IN && prom_sel && UDS_IN;
  assign PROMCS1   = RUN_IN && AS_IN && prom_sel && LDS_IN;
  assign SRAMCS0   = RUN_IN && AS_IN && sram_sel && UDS_IN;
  assign SRAMCS1   = RUN_IN && AS_IN && sram_sel && LDS_IN;
  assign OE        = RUN_IN && AS_IN && (prom_sel || sram_sel) && !WR_IN;
  assign dtreq     = AS_IN && (UDS_IN || LDS_IN);
  assign step_rise = step_sync_q && !step_prev_q;

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    wait_d    = wait_q;
    to_d      = to_q;
    idx_d     = idx_q;
    in_d      = in_q;
    read_d    = read_q;
    ack_entry = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dtreq) begin
          region_d = region;
          idx_d    = port_idx;
          in_d     = port_in;
          read_d   = !WR_IN;
          to_d     = '0;
          if (region == REG_UNMAPPED) begin
            state_d = S_BERR;
          end else begin
            state_d = S_WAIT;
            if (region == REG_IO)  wait_d = wait_load(IO_WAIT);
            else if (prom_sel)     wait_d = wait_load(PROM_WAIT);
            else                   wait_d = wait_load(SRAM_WAIT);
          end
        end
      end
      S_WAIT: begin
        if (!dtreq) begin
          state_d = S_IDLE;
        end else if (wait_q == '0) begin
          state_d   = STEPEN_IN ? S_PAUSE : S_ACK;
          ack_entry = !STEPEN_IN;
        end else if (!STEPEN_IN && (to_q == TO_LAST)) begin
          state_d = S_BERR;
        end else begin
          wait_d = wait_q - 4'd1;
          if (!STEPEN_IN) to_d = to_q + 16'd1;
        end
      end
      S_PAUSE: begin
        if (!dtreq) begin
          state_d = S_IDLE;
        end else if (step_rise) begin
          state_d   = S_ACK;
          ack_entry = 1'b1;
        end
      end
      S_ACK, S_BERR: begin
        if (!dtreq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_byte = '0;
    out_d   = out_q;
    boot_d  = boot_q;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (idx_q == 4'(k)) begin
        rd_byte = in_q ? INPUT_SIGNAL_IN[8*k +: 8] : out_q[8*k +: 8];
        if (ack_entry && (region_q == REG_IO) && !in_q && WR_IN && LDS_IN)
          out_d[8*k +: 8] = DATA_IN[7:0];
      end
    end
    if (ack_entry && (region_q == REG_LOWER) && WR_IN) boot_d = 1'b1;
    // BERR and DATA_OE only assert from the edge after the cycle is accepted
    dtack_d = (state_d == S_ACK);
    berr_d  = (state_d == S_BERR) && (state_q != S_IDLE);
    doe_d   = (state_d != S_IDLE) && (state_q != S_IDLE) && (region_q == REG_IO) && read_q;
    dout_d  = doe_d ? {8'h00, rd_byte} : dout_q;
  end

  always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state_q     <= S_IDLE;
      region_q    <= REG_UNMAPPED;
      wait_q      <= '0;
      to_q        <= '0;
      idx_q       <= '0;
      in_q        <= 1'b0;
      read_q      <= 1'b0;
      boot_q      <= 1'b0;
      dtack_q     <= 1'b0;
      berr_q      <= 1'b0;
      doe_q       <= 1'b0;
      dout_q      <= '0;
      out_q       <= '0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      wait_q      <= wait_d;
      to_q        <= to_d;
      idx_q       <= idx_d;
      in_q        <= in_d;
      read_q      <= read_d;
      boot_q      <= boot_d;
      dtack_q     <= dtack_d;
      berr_q      <= berr_d;
      doe_q       <= doe_d;
      dout_q      <= dout_d;
      out_q       <= out_d;
      step_sync_q <= STEP_IN;
      step_prev_q <= step_sync_q;
    end
  end

  assign DTACK         = dtack_q;
  assign BERR          = berr_q;
  assign DATA_OE       = doe_q;
  assign DATA_OUT      = dout_q;
  assign OUTPUT_SIGNAL = out_q;

endmodule
